// File: rtl/life_pkg.sv
// Shared state type, defaults and sizing helper for the Life generation controller.
package life_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CLEAR} state_t;

  localparam int unsigned GEN_W_DEF = 16;

  // Width of the divider counter: enough bits to hold 0..tick_div-1.
  function automatic int unsigned div_width(input int unsigned tick_div);
    return (tick_div > 2) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/life_gen_ctrl_if.sv
// Row-load stream between a pattern source and the Life generation controller.
interface life_gen_ctrl_if #(
  parameter int unsigned COLS = 16
) ();
  logic            load_valid;
  logic            load_ready;
  logic [COLS-1:0] load_data;
  logic            load_last;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/life_tick_div.sv
// Generation-rate divider: counts 0..TICK_DIV-1 while enabled, tick on the terminal count.
module life_tick_div
  import life_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = div_width(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/life_gen_ctrl.sv
// Life array sequencer: row loading, generation pulses (run/step), clear and generation count.
// Optional generation limit in RUN enabled by defining LIFE_GEN_CTRL_GEN_LIMIT_EN.
module life_gen_ctrl
  import life_pkg::*;
#(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned COLS     = 16,
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned GEN_W    = GEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_clear,
  life_gen_ctrl_if.slave   load,
  output logic [ROWS-1:0]  row_write,
  output logic [COLS-1:0]  row_val,
  output logic             cell_enb,
  output logic             cell_clear,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy
`ifdef LIFE_GEN_CTRL_GEN_LIMIT_EN
  ,
  input  logic [GEN_W-1:0] gen_limit,
  output logic             limit_hit
`endif
);

  localparam int unsigned PW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t state, state_n;

  logic            step_d, clear_d, step_edge, clear_edge;
  logic [PW-1:0]   row_ptr, row_ptr_n;
  logic [ROWS-1:0] row_write_n;
  logic [COLS-1:0] row_val_n;
  logic            enb_n, clr_n;
  logic [GEN_W-1:0] gen_n, gen_inc;
  logic            accept, load_end, run_go, tick;
  logic            limit_q, limit_reached;

  assign step_edge  = cmd_step & ~step_d;
  assign clear_edge = cmd_clear & ~clear_d;
  assign gen_inc    = gen_count + GEN_W'(1);
  assign load_end   = load.load_last || (row_ptr == PW'(ROWS - 1));

  // A clear edge in IDLE outranks a beat offered in the same cycle.
  assign accept = load.load_valid && load.load_ready &&
                  ((state == LOAD) || (state == IDLE && !clear_edge));

  assign run_go = (state == RUN) && cmd_run && !clear_edge;

  life_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .clr   (!run_go),
    .en    (run_go),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      step_d          <= 1'b0;
      clear_d         <= 1'b0;
      row_ptr         <= '0;
      row_write       <= '0;
      row_val         <= '0;
      cell_enb        <= 1'b0;
      cell_clear      <= 1'b0;
      gen_count       <= '0;
      busy            <= 1'b0;
      load.load_ready <= 1'b0;
    end else begin
      state           <= state_n;
      step_d          <= cmd_step;
      clear_d         <= cmd_clear;
      row_ptr         <= row_ptr_n;
      row_write       <= row_write_n;
      row_val         <= row_val_n;
      cell_enb        <= enb_n;
      cell_clear      <= clr_n;
      gen_count       <= gen_n;
      busy            <= (state_n != IDLE);
      load.load_ready <= (state_n == IDLE) || (state_n == LOAD);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (clear_edge)                state_n = CLEAR;
        else if (accept)               state_n = load_end ? IDLE : LOAD;
        else if (step_edge)            state_n = IDLE;
        else if (cmd_run && !limit_q)  state_n = RUN;
      end
      LOAD: begin
        if (accept && load_end) state_n = IDLE;
      end
      RUN: begin
        if (clear_edge)                   state_n = CLEAR;
        else if (!cmd_run)                state_n = IDLE;
        else if (tick && limit_reached)   state_n = IDLE;
      end
      CLEAR: state_n = IDLE;
    endcase
  end

  always_comb begin
    row_write_n = '0;
    row_val_n   = '0;
    row_ptr_n   = row_ptr;
    enb_n       = 1'b0;
    clr_n       = 1'b0;
    gen_n       = gen_count;
    if (accept) begin
      row_write_n = ROWS'(1) << row_ptr;
      row_val_n   = load.load_data;
      row_ptr_n   = load_end ? '0 : row_ptr + PW'(1);
    end
    if (state_n == CLEAR) begin
      clr_n = 1'b1;
      gen_n = '0;
    end
    if ((state == IDLE && !clear_edge && !accept && step_edge) || (run_go && tick)) begin
      enb_n = 1'b1;
      gen_n = gen_inc;
    end
  end

`ifdef LIFE_GEN_CTRL_GEN_LIMIT_EN
  assign limit_reached = (gen_limit != '0) && (gen_inc == gen_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      limit_q <= 1'b0;
    end else if (accept || state_n == CLEAR) begin
      limit_q <= 1'b0;
    end else if (run_go && tick && limit_reached) begin
      limit_q <= 1'b1;
    end
  end

  assign limit_hit = limit_q;
`else
  assign limit_reached = 1'b0;
  assign limit_q       = 1'b0;
`endif

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Self-checking bench for life_gen_ctrl: vector table, directed corner sequences, random vs model.
module tb_life_gen_ctrl;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int TICK_DIV = 4;
  localparam int GEN_W    = 4;

  logic             clk = 1'b0;
  logic             reset, cmd_run, cmd_step, cmd_clear;
  logic [ROWS-1:0]  row_write;
  logic [COLS-1:0]  row_val;
  logic             cell_enb, cell_clear, busy;
  logic [GEN_W-1:0] gen_count;
`ifdef LIFE_GEN_CTRL_GEN_LIMIT_EN
  logic [GEN_W-1:0] gen_limit;
  logic             limit_hit;
`endif

  life_gen_ctrl_if #(.COLS(COLS)) lif ();

  life_gen_ctrl #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV), .GEN_W(GEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_run    (cmd_run),
    .cmd_step   (cmd_step),
    .cmd_clear  (cmd_clear),
    .load       (lif.slave),
    .row_write  (row_write),
    .row_val    (row_val),
    .cell_enb   (cell_enb),
    .cell_clear (cell_clear),
    .gen_count  (gen_count),
    .busy       (busy)
`ifdef LIFE_GEN_CTRL_GEN_LIMIT_EN
    ,
    .gen_limit  (gen_limit),
    .limit_hit  (limit_hit)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: activity flags plus a countdown to the next generation.
  bit       m_loading, m_running, m_clearing, m_ready, m_hit, m_busy;
  bit       m_enb, m_clr, p_step, p_clear;
  bit [3:0] m_wr, m_val;
  int       m_row, m_wait, m_gen;

  task automatic start_clear();
    m_running  = 0;
    m_clearing = 1;
    m_clr      = 1;
    m_gen      = 0;
    m_hit      = 0;
  endtask

  task automatic take_beat();
    m_wr  = 4'(1 << m_row);
    m_val = lif.load_data;
    m_hit = 0;
    if (lif.load_last || m_row == ROWS - 1) begin
      m_loading = 0;
      m_row     = 0;
    end else begin
      m_loading = 1;
      m_row++;
    end
  endtask

  task automatic pulse(input bit from_run);
    m_enb = 1;
    m_gen = (m_gen + 1) % (1 << GEN_W);
`ifdef LIFE_GEN_CTRL_GEN_LIMIT_EN
    if (from_run && gen_limit != 0 && m_gen == int'(gen_limit)) begin
      m_running = 0;
      m_hit     = 1;
    end
`else
    if (from_run) m_wait = TICK_DIV;
`endif
  endtask

  task automatic model_edge();
    bit se, ce;
    m_wr = '0; m_val = '0; m_enb = 0; m_clr = 0;
    if (reset) begin
      m_loading = 0; m_running = 0; m_clearing = 0; m_ready = 0; m_hit = 0;
      m_busy = 0; m_row = 0; m_gen = 0; p_step = 0; p_clear = 0;
      return;
    end
    se = cmd_step && !p_step;
    ce = cmd_clear && !p_clear;
    p_step  = cmd_step;
    p_clear = cmd_clear;
    if (m_clearing) begin
      m_clearing = 0;
    end else if (m_loading) begin
      if (lif.load_valid && m_ready) take_beat();
    end else if (m_running) begin
      if (ce) start_clear();
      else if (!cmd_run) m_running = 0;
      else begin
        m_wait--;
        if (m_wait == 0) begin
          m_wait = TICK_DIV;
          pulse(1);
        end
      end
    end else begin
      if (ce) start_clear();
      else if (lif.load_valid && m_ready) take_beat();
      else if (se) pulse(0);
      else if (cmd_run && !m_hit) begin
        m_running = 1;
        m_wait    = TICK_DIV;
      end
    end
    m_ready = !m_running && !m_clearing;
    m_busy  = m_loading || m_running || m_clearing;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("row_write", row_write, m_wr);
    if (m_wr != 0) chk("row_val", row_val, m_val);
    chk("cell_enb", cell_enb, m_enb);
    chk("cell_clear", cell_clear, m_clr);
    chk("gen_count", gen_count, m_gen);
    chk("busy", busy, m_busy);
    chk("load_ready", lif.load_ready, m_ready);
    chk("exclusive", int'((cell_clear && row_write != 0) || (cell_enb && (cell_clear || row_write != 0))), 0);
`ifdef LIFE_GEN_CTRL_GEN_LIMIT_EN
    chk("limit_hit", limit_hit, m_hit);
`endif
  endtask

  typedef struct {
    bit run, step, clear, valid, last;
    bit [3:0] data, rw, val;
    bit enb, clr, bsy;
    int gen;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit run, bit step, bit clear, bit valid, bit last, bit [3:0] data,
                              bit [3:0] rw, bit [3:0] val, bit enb, bit clr, bit bsy, int gen);
    vec_t v;
    v.run = run; v.step = step; v.clear = clear; v.valid = valid; v.last = last; v.data = data;
    v.rw = rw; v.val = val; v.enb = enb; v.clr = clr; v.bsy = bsy; v.gen = gen;
    return v;
  endfunction

  initial begin
    int np, first, n;
    bit seen;

    //                run st cl va la data   rw   val  enb clr bsy gen
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'h1, 4'h1, 4'h1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'h2, 4'h2, 4'h2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'h4, 4'h4, 4'h4, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 4'h8, 4'h8, 4'h8, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'h5, 4'h1, 4'h5, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 4'hA, 4'h2, 4'hA, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'h3, 4'h1, 4'h3, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 4'h6, 4'h2, 4'h6, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 4'h9, 4'h4, 4'h9, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 4'hC, 4'h8, 4'hC, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 4'hF, 4'h1, 4'hF, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 4'h0, 4'h2, 4'h0, 0, 0, 0, 0));

    reset = 1; cmd_run = 0; cmd_step = 0; cmd_clear = 0;
    lif.load_valid = 0; lif.load_data = '0; lif.load_last = 0;
`ifdef LIFE_GEN_CTRL_GEN_LIMIT_EN
    gen_limit = '0;
`endif
    cycle();
    cycle();
    chk("reset_row_write", row_write, 0);
    chk("reset_cell_enb", cell_enb, 0);
    chk("reset_cell_clear", cell_clear, 0);
    chk("reset_gen_count", gen_count, 0);
    chk("reset_load_ready", lif.load_ready, 0);
    chk("reset_busy", busy, 0);
    reset = 0;

    foreach (tbl[i]) begin
      cmd_run = tbl[i].run; cmd_step = tbl[i].step; cmd_clear = tbl[i].clear;
      lif.load_valid = tbl[i].valid; lif.load_last = tbl[i].last; lif.load_data = tbl[i].data;
      cycle();
      chk($sformatf("vec%0d.row_write", i), row_write, tbl[i].rw);
      if (tbl[i].rw != 0) chk($sformatf("vec%0d.row_val", i), row_val, tbl[i].val);
      chk($sformatf("vec%0d.cell_enb", i), cell_enb, tbl[i].enb);
      chk($sformatf("vec%0d.cell_clear", i), cell_clear, tbl[i].clr);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d.gen_count", i), gen_count, tbl[i].gen);
    end
    cmd_run = 0; cmd_step = 0; cmd_clear = 0; lif.load_valid = 0; lif.load_last = 0;
    cycle();

    // Free run: first pulse TICK_DIV cycles after RUN entry, then every TICK_DIV.
    np = 0; first = 0;
    for (int i = 1; i <= 21; i++) begin
      cmd_run = 1;
      cycle();
      if (cell_enb) begin
        np++;
        if (first == 0) first = i;
      end
    end
    chk("run_first_pulse", first, 5);
    chk("run_pulses", np, 5);
    cmd_run = 0; np = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (cell_enb) np++;
    end
    chk("pulses_after_drop", np, 0);
    chk("gen_after_run", gen_count, 5);

    // Clear mid-run at gen_count 3; run resumes from IDLE.
    cmd_clear = 1; cycle(); cmd_clear = 0; cycle();
    cmd_run = 1;
    for (int i = 0; i < 13; i++) cycle();
    chk("gen_before_clear", gen_count, 3);
    cmd_clear = 1;
    cycle();
    chk("run_clear_pulse", cell_clear, 1);
    chk("run_clear_no_enb", cell_enb, 0);
    chk("run_clear_gen", gen_count, 0);
    seen = 0; n = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      cycle();
      if (cell_enb) begin
        seen = 1;
        n = i;
      end
    end
    chk("resume_after_clear", n, 6);
    cmd_run = 0; cmd_clear = 0;
    cycle(); cycle();

    // Counter wrap: 17 steps from zero land on 1.
    cmd_clear = 1; cycle(); cmd_clear = 0; cycle();
    for (int i = 0; i < 17; i++) begin
      cmd_step = 1; cycle();
      cmd_step = 0; cycle();
    end
    chk("gen_wrap", gen_count, 1);

    // Reset mid-load abandons the load.
    lif.load_valid = 1; lif.load_data = 4'h7;
    cycle(); cycle();
    reset = 1;
    cycle();
    reset = 0; lif.load_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_midload_row_write", row_write, 0);
    end
    chk("reset_midload_busy", busy, 0);

`ifdef LIFE_GEN_CTRL_GEN_LIMIT_EN
    gen_limit = 4'd2;
    cmd_run = 1; np = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (cell_enb) np++;
    end
    chk("limit_pulses", np, 2);
    chk("limit_hit_set", limit_hit, 1);
    chk("limit_idle", busy, 0);
    chk("limit_gen", gen_count, 2);
    cmd_clear = 1;
    cycle();
    chk("limit_hit_cleared", limit_hit, 0);
    cmd_clear = 0; cmd_run = 0;
    cycle(); cycle();
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 29) == 0) cmd_run = ~cmd_run;
      if ($urandom_range(0, 3) == 0) cmd_step = ~cmd_step;
      cmd_clear      = ($urandom_range(0, 59) == 0);
      lif.load_valid = ($urandom_range(0, 3) == 0);
      lif.load_data  = 4'($urandom);
      lif.load_last  = ($urandom_range(0, 3) == 0);
`ifdef LIFE_GEN_CTRL_GEN_LIMIT_EN
      if ($urandom_range(0, 199) == 0) gen_limit = 4'($urandom_range(0, 6));
`endif
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
Upstream sequencer for the Life cell array. It loads an initial pattern row by row through a valid/ready stream, driving each cell's write/val pins. It issues single-cycle generation-enable pulses to every cell's enb pin, either free-running at a divided rate or single-stepped. It also drives the array-wide clear and keeps a generation counter.

Parameters:
ROWS, 16, number of array rows; one-hot row write strobes.
COLS, 16, cells per row; width of the load data word.
TICK_DIV, 1000000, clk cycles between generations in RUN; must be >= 2.
GEN_W, 16, generation counter width.

Ports:
clk  in  1  clock.
reset  in  1  reset, synchronous, active-high.
cmd_run  in  1  level; high = free-run generations.
cmd_step  in  1  rising edge = advance exactly one generation.
cmd_clear  in  1  rising edge = clear array and counter.
load_valid  in  1  load beat valid.
load_ready  out  1  load beat accepted when load_valid && load_ready.
load_data  in  COLS  row contents; bit c = cell column c.
load_last  in  1  final row of the pattern.
row_write  out  ROWS  one-hot; row_write[r] drives write of every cell in row r.
row_val  out  COLS  row_val[c] drives val of every cell in column c.
cell_enb  out  1  enb of all cells; one-cycle pulse per generation.
cell_clear  out  1  reset pin of all cells; one-cycle pulse.
gen_count  out  GEN_W  generations issued since last clear/reset.
busy  out  1  high in LOAD, RUN, CLEAR.

Behaviour:
- All outputs are registered. On reset: state IDLE; row_write=0, row_val=0, cell_enb=0, cell_clear=0, gen_count=0, load_ready=0, busy=0; row pointer, divider and edge detectors cleared. Reset mid-load abandons the load, with no partial write issued afterward.
- load_ready is registered: 1 in IDLE and LOAD, 0 elsewhere.
- States: IDLE, LOAD, RUN, CLEAR.
- Command priority in IDLE, same cycle: clear edge > load_valid > step edge > cmd_run.
- IDLE, load beat accepted: enter LOAD with row_ptr=0.
- Every accepted beat: the next cycle has row_write = one-hot(row_ptr), row_val = load_data. row_ptr then increments.
- LOAD ends when load_last is set or row_ptr==ROWS-1. The state returns to IDLE and row_ptr is cleared. Rows not written keep prior contents.
- LOAD ignores step, run and clear. A clear edge during LOAD is dropped, not queued.
- IDLE, step edge: cell_enb=1 for exactly the next cycle; gen_count+1.
- IDLE, cmd_run=1: enter RUN with divider=0.
- RUN:
  - The divider counts 0..TICK_DIV-1. On reaching TICK_DIV-1 it wraps to 0 and cell_enb pulses the following cycle, with gen_count+1. The first pulse therefore comes TICK_DIV cycles after entering RUN.
  - cmd_run=0: return to IDLE and clear the divider; no pulse is issued that cycle.
  - Clear edge: go to CLEAR, overriding run.
  - Step edges and load_valid are ignored (load_ready=0).
- CLEAR: cell_clear=1 for one cycle and gen_count=0, then IDLE. If cmd_run is still high, RUN resumes from IDLE on the next cycle.
- cell_clear and row_write are never asserted in the same cycle, since the cell's write overrides its reset. cell_enb is never asserted with either.
- gen_count wraps modulo 2^GEN_W.
- Edge detectors sample cmd_step/cmd_clear every cycle, including in states that ignore them. A held level never re-triggers.

Optional Feature:
LIFE_GEN_CTRL_GEN_LIMIT_EN
- Defined: adds input gen_limit (GEN_W) and output limit_hit (1, reset 0).
  - In RUN, the pulse that makes gen_count == gen_limit forces IDLE and sets limit_hit.
  - limit_hit clears on clear or load.
  - gen_limit=0 disables the limit.
  - Steps are not limited.
- Undefined: no such ports; RUN is unbounded.

Decomposition:
- Package life_pkg holds:
  - state enum (IDLE, LOAD, RUN, CLEAR);
  - GEN_W default;
  - a localparam function for divider width, clog2(TICK_DIV).
- One sub-module, life_tick_div. It is the divider, with clear input, enable, and a one-cycle terminal output, instantiated in RUN control.

Test Plan:
- ROWS=4,COLS=4: reset, load beats 0x1,0x2,0x4,0x8 (last on 4th) -> row_write 0001,0010,0100,1000 with matching row_val, one cycle after each acceptance; back to IDLE.
- Load 2 beats, load_valid low 5 cycles, then 2 beats with load_last -> row_write stays 0 during gap; rows written in order 0..3.
- TICK_DIV=4, cmd_run high 20 cycles -> cell_enb pulses every 4 cycles, first 4 cycles after RUN entry; gen_count=5 after run drops; no enb after drop.
- IDLE, cmd_step held high 10 cycles -> exactly one cell_enb pulse; gen_count=1.
- During RUN with gen_count=3, clear edge -> cell_clear one cycle, gen_count=0, no cell_enb that cycle; RUN resumes with cmd_run high.
- With LIFE_GEN_CTRL_GEN_LIMIT_EN, gen_limit=2, TICK_DIV=4 -> two pulses, then IDLE, limit_hit=1 with cmd_run still high.
